// File: rtl/dc_pkg.sv
// rtl/dc_pkg.sv - shared FSM state type and width defaults for the distance-calculator scheduler
package dc_pkg;

    localparam int DC_WORD_WIDTH = 8;
    localparam int DC_DIST_WIDTH = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } dc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or above ptr, with wrap
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] idx
);

    localparam logic [ID_WIDTH:0] N_W = (ID_WIDTH+1)'(NUM_REQ);

    logic [ID_WIDTH:0] cand;
    logic              found;

    // One extra bit on cand so ptr+off never overflows before the wrap subtraction.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr} + (ID_WIDTH+1)'(off);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && req[cand[ID_WIDTH-1:0]]) begin
                found                      = 1'b1;
                grant[cand[ID_WIDTH-1:0]]  = 1'b1;
                idx                        = cand[ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/dist_calc_scheduler.sv
// rtl/dist_calc_scheduler.sv - shares one DistCalc engine between NUM_REQ requesters, one job in flight
module dist_calc_scheduler
    import dc_pkg::*;
#(
    parameter int WORD_WIDTH = DC_WORD_WIDTH,
    parameter int DIST_WIDTH = DC_DIST_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 255,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [WORD_WIDTH-1:0]          cfg_ke_width,
    input  logic [WORD_WIDTH-1:0]          cfg_of_width,
    input  logic [WORD_WIDTH-1:0]          cfg_stride,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]  req_idx1,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]  req_idx2,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DIST_WIDTH-1:0]          rsp_dist,
    output logic                           rsp_exception,
    output logic                           rsp_timeout,
    output logic                           eng_enable,
    output logic [WORD_WIDTH-1:0]          eng_ke_width,
    output logic [WORD_WIDTH-1:0]          eng_of_width,
    output logic [WORD_WIDTH-1:0]          eng_stride,
    output logic [WORD_WIDTH-1:0]          eng_idx1,
    output logic [WORD_WIDTH-1:0]          eng_idx2,
    input  logic                           eng_valid,
    input  logic                           eng_exception,
    input  logic [DIST_WIDTH-1:0]          eng_dist,
    output logic                           busy
);

    localparam int                  TW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW:0]         TO_LIM  = (TW+1)'(TIMEOUT);
    localparam logic [TW-1:0]       TO_MAX  = '1;
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    dc_state_t            state, state_nxt;
    logic [ID_WIDTH-1:0]  rr_ptr;
    logic [ID_WIDTH-1:0]  winner;
    logic [NUM_REQ-1:0]   winner_oh;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [ID_WIDTH-1:0]  arb_idx;
    logic [TW-1:0]        to_cnt;
    logic                 to_hit;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Fires in the TIMEOUT-th RUN cycle, so enable is held exactly TIMEOUT cycles on a hang.
    assign to_hit = (TIMEOUT != 0) && (({1'b0, to_cnt} + 1'b1) == TO_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = ST_IDLE;
        req_ready  = '0;
        eng_enable = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                state_nxt = (|req_valid) ? ST_GRANT : ST_IDLE;
            end
            ST_GRANT: begin
                req_ready = winner_oh;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                eng_enable = 1'b1;
                state_nxt  = (eng_valid || to_hit) ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                state_nxt = eng_valid ? ST_DRAIN : ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            winner        <= '0;
            winner_oh     <= '0;
            to_cnt        <= '0;
            eng_ke_width  <= '0;
            eng_of_width  <= '0;
            eng_stride    <= '0;
            eng_idx1      <= '0;
            eng_idx2      <= '0;
            rsp_id        <= '0;
            rsp_dist      <= '0;
            rsp_exception <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        winner    <= arb_idx;
                        winner_oh <= arb_grant;
                    end
                end
                ST_GRANT: begin
                    eng_idx1     <= req_idx1[winner*WORD_WIDTH +: WORD_WIDTH];
                    eng_idx2     <= req_idx2[winner*WORD_WIDTH +: WORD_WIDTH];
                    eng_ke_width <= cfg_ke_width;
                    eng_of_width <= cfg_of_width;
                    eng_stride   <= cfg_stride;
                    rr_ptr       <= (winner == LAST_ID) ? '0 : winner + 1'b1;
                    to_cnt       <= '0;
                end
                ST_RUN: begin
                    if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    if (eng_valid) begin
                        rsp_id        <= winner;
                        rsp_dist      <= eng_dist;
                        rsp_exception <= eng_exception;
                        rsp_timeout   <= 1'b0;
                    end else if (to_hit) begin
                        rsp_id        <= winner;
                        rsp_dist      <= '0;
                        rsp_exception <= 1'b0;
                        rsp_timeout   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
